// File: rtl/sign_extender.sv
// Immediate-field extension unit: widens an IN_W-bit immediate to the OUT_W-bit
// datapath word, with a mode-selected extension and a registered copy for branch logic.
module sign_extender #(
  parameter int IN_W  = 12,
  parameter int OUT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IN_W-1:0]  in,
  input  logic [1:0]       mode,
  input  logic             load,
  output logic [OUT_W-1:0] out,
  output logic [OUT_W-1:0] ext,
  output logic [OUT_W-1:0] out_q,
  output logic             q_valid,
  output logic             is_neg
);

  logic [OUT_W-1:0] zext;
  logic [OUT_W-1:0] sext8;
  logic [OUT_W-1:0] ext_next;
  logic [OUT_W-1:0] out_q_reg;
  logic             q_valid_reg;

  // Full-immediate sign extension: low bits pass through, upper bits replicate the MSB.
  assign out[IN_W-1:0] = in;
  generate
    for (genvar gi = IN_W; gi < OUT_W; gi++) begin : g_sext
      assign out[gi] = in[IN_W-1];
    end
  endgenerate

  assign zext   = {{(OUT_W-IN_W){1'b0}}, in};
  assign is_neg = in[IN_W-1];

  // Byte-immediate form only exists when the field is at least a byte wide.
  generate
    if (IN_W >= 8) begin : g_sext8
      assign sext8 = {{(OUT_W-8){in[7]}}, in[7:0]};
    end else begin : g_no_sext8
      assign sext8 = out;
    end
  endgenerate

  always_comb begin
    ext_next = out;
    case (mode)
      2'b00:   ext_next = out;
      2'b01:   ext_next = zext;
      2'b10:   ext_next = sext8;
      2'b11:   ext_next = {out[OUT_W-2:0], 1'b0};
      default: ext_next = out;
    endcase
  end

  assign ext = ext_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q_reg   <= '0;
      q_valid_reg <= 1'b0;
    end else if (load) begin
      out_q_reg   <= ext_next;
      q_valid_reg <= 1'b1;
    end
  end

  assign out_q   = out_q_reg;
  assign q_valid = q_valid_reg;

endmodule

// File: tb/tb_sign_extender.sv
// Directed and random checks for sign_extender: combinational extension modes,
// the load register, and asynchronous reset behaviour.
module tb_sign_extender;

  logic        clk;
  logic        clk_en;
  logic        rst_n;
  logic [11:0] in;
  logic [1:0]  mode;
  logic        load;
  logic [15:0] out;
  logic [15:0] ext;
  logic [15:0] out_q;
  logic        q_valid;
  logic        is_neg;

  int n_cmp;
  int n_err;

  sign_extender #(.IN_W(12), .OUT_W(16)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .in      (in),
    .mode    (mode),
    .load    (load),
    .out     (out),
    .ext     (ext),
    .out_q   (out_q),
    .q_valid (q_valid),
    .is_neg  (is_neg)
  );

  // Clock only runs once enabled, so the first checks happen with no clock at all.
  initial clk = 1'b0;
  always begin
    #5;
    if (clk_en) clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end else begin
      $display("ok   %s: %h", tag, got);
    end
  endtask

  typedef struct {
    logic [11:0] in;
    logic [1:0]  mode;
    logic [15:0] ext;
  } vec_t;

  vec_t vecs[10];

  initial begin
    n_cmp  = 0;
    n_err  = 0;
    clk_en = 1'b0;
    rst_n  = 1'b1;
    load   = 1'b0;
    mode   = 2'b00;
    in     = 12'b1000_0000_0000;

    // Combinational path with no clock and no reset.
    #100;
    check("noclk_out", 32'(out), 32'h0000_F800);
    check("noclk_isneg", 32'(is_neg), 32'h1);
    in = 12'h7FF; #10;
    check("out_7ff", 32'(out), 32'h0000_07FF);
    check("isneg_7ff", 32'(is_neg), 32'h0);
    in = 12'hFFF; #10;
    check("out_fff", 32'(out), 32'h0000_FFFF);

    // Mode table, including byte-form and shift boundaries.
    vecs[0] = '{12'h8A5, 2'b00, 16'hF8A5};
    vecs[1] = '{12'h8A5, 2'b01, 16'h08A5};
    vecs[2] = '{12'h8A5, 2'b10, 16'hFFA5};
    vecs[3] = '{12'h8A5, 2'b11, 16'hF14A};
    vecs[4] = '{12'h87F, 2'b10, 16'h007F};
    vecs[5] = '{12'h080, 2'b10, 16'hFF80};
    vecs[6] = '{12'h7FF, 2'b11, 16'h0FFE};
    vecs[7] = '{12'h800, 2'b11, 16'hF000};
    vecs[8] = '{12'hFFF, 2'b01, 16'h0FFF};
    vecs[9] = '{12'h000, 2'b11, 16'h0000};
    for (int i = 0; i < 10; i++) begin
      in   = vecs[i].in;
      mode = vecs[i].mode;
      #10;
      check($sformatf("ext_in%h_m%0d", vecs[i].in, vecs[i].mode), 32'(ext), 32'(vecs[i].ext));
    end
    in = 12'h8A5; mode = 2'b01; #10;
    check("out_mode_indep", 32'(out), 32'h0000_F8A5);

    // Asynchronous reset with the clock stopped.
    rst_n = 1'b0; #3;
    check("rst_outq", 32'(out_q), 32'h0);
    check("rst_qvalid", 32'(q_valid), 32'h0);

    clk_en = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    mode  = 2'b11;
    in    = 12'h004;
    load  = 1'b1;
    @(posedge clk); #1;
    check("load_outq", 32'(out_q), 32'h0000_0008);
    check("load_qvalid", 32'(q_valid), 32'h1);

    @(negedge clk);
    load = 1'b0;
    in   = 12'h123;
    repeat (3) @(posedge clk);
    #1;
    check("hold_outq", 32'(out_q), 32'h0000_0008);
    check("hold_qvalid", 32'(q_valid), 32'h1);

    // Back-to-back loads overwrite each cycle.
    @(negedge clk);
    load = 1'b1; mode = 2'b01; in = 12'h8A5;
    @(posedge clk); #1;
    check("b2b_first", 32'(out_q), 32'h0000_08A5);
    @(negedge clk);
    mode = 2'b00; in = 12'hF00;
    @(posedge clk); #1;
    check("b2b_second", 32'(out_q), 32'h0000_FF00);

    // Reset between edges clears immediately; a load on an edge during reset is lost.
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_outq", 32'(out_q), 32'h0);
    check("midrst_qvalid", 32'(q_valid), 32'h0);
    @(posedge clk); #1;
    check("rst_load_ignored", 32'(out_q), 32'h0);

    // First edge after release captures with no recovery cycle.
    @(negedge clk);
    rst_n = 1'b1; mode = 2'b10; in = 12'h3C1;
    @(posedge clk); #1;
    check("release_outq", 32'(out_q), 32'h0000_FFC1);
    check("release_qvalid", 32'(q_valid), 32'h1);
    @(negedge clk);
    load = 1'b0;

    // Random vectors, mode 00: out and ext equal the signed value of in.
    mode = 2'b00;
    for (int i = 0; i < 1000; i++) begin
      logic [11:0] v;
      int          e;
      logic [31:0] eu;
      v  = 12'($urandom_range(0, 4095));
      in = v;
      e  = $signed(v);
      eu = e;
      #1;
      check($sformatf("rnd_out_%h", v), 32'(out), 32'(eu[15:0]));
      check($sformatf("rnd_ext_%h", v), 32'(ext), 32'(eu[15:0]));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/sign_extender.md
# sign_extender

Immediate-field extension unit for the processor datapath. It widens a 12-bit instruction immediate to the 16-bit datapath word. `out` is a purely combinational sign extension that feeds the ALU and stack operand path. A mode-selected extension (`ext`) and a registered copy (`out_q`, `q_valid`) serve the branch/jump offset logic, which needs the value held across a cycle.

## Interface
- `IN_W`, default 12: immediate width.
  - Must satisfy 2 ≤ `IN_W` < `OUT_W`.
  - Mode 10 additionally requires `IN_W` ≥ 8.
- `OUT_W`, default 16: datapath word width.
- `clk`  input  1  single clock; all state is rising-edge triggered.
- `rst_n`  input  1  asynchronous, active-low reset.
- `in`  input  `IN_W`  immediate field.
- `out`  output  `OUT_W`  combinational sign extension of `in`.
- `mode`  input  2  extension mode for `ext`.
- `ext`  output  `OUT_W`  combinational mode-selected extension.
- `load`  input  1  capture `ext` into `out_q` on the next rising edge.
- `out_q`  output  `OUT_W`  registered extension.
- `q_valid`  output  1  `out_q` holds a captured value.
- `is_neg`  output  1  combinational copy of `in[IN_W-1]`.

## Operation
- `out`:
  - `out[IN_W-1:0] = in`.
  - `out[OUT_W-1:IN_W]` = copies of `in[IN_W-1]`.
  - Independent of `clk`, `rst_n`, `mode` and `load`; valid even with no clock running or reset asserted.
- `ext` by `mode`:
  - 00: same as `out` (sign-extend the full immediate).
  - 01: zero-extend; upper `OUT_W-IN_W` bits are 0.
  - 10: sign-extend `in[7:0]`; `in[IN_W-1:8]` is ignored.
  - 11: branch offset = (sign-extended `in`) << 1.
    - Bit 0 is 0.
    - The former bit `OUT_W-1` is discarded; no saturation.
  - `mode` X/Z: `ext` is don't-care, but `out` is unaffected.
- Register:
  - On a rising edge with `load`=1: `out_q` ← `ext`, `q_valid` ← 1.
  - With `load`=0: `out_q` and `q_valid` hold.
- Reset (`rst_n`=0):
  - `out_q` = 0 and `q_valid` = 0 immediately, regardless of `clk`.
  - Held while low; `load` is ignored during reset.
- Reset released: the first rising edge with `load`=1 captures normally. There is no extra recovery cycle.
- `is_neg` = `in[IN_W-1]` for every mode.

## Timing
- `out`, `ext`, `is_neg`: zero-cycle combinational latency.
  - Settle within a single propagation delay of a change on `in` or `mode`.
  - Must be stable well within 100 ns.
- `out_q`/`q_valid`: one-cycle latency.
  - Reflect the `ext` value sampled at the rising edge where `load`=1.
- Back-to-back loads: each edge with `load`=1 overwrites `out_q`; no pipelining and no backpressure.
- Reset asserted mid-operation: clears `out_q` and `q_valid` asynchronously. Any load on the same edge is lost.
- Reset values:
  - `out_q` = 16'h0000, `q_valid` = 0.
  - Combinational outputs follow their inputs and have no reset value.

## Test plan
- `in`=12'b1000_0000_0000, no clock, `rst_n` unconnected or high -> after 100 ns `out`=16'hF800 and `is_neg`=1.
- `in`=12'h7FF -> `out`=16'h07FF and `is_neg`=0; `in`=12'hFFF -> `out`=16'hFFFF.
- `in`=12'h8A5, sweep `mode` 00/01/10/11 -> `ext`=16'hF8A5 / 16'h08A5 / 16'hFFA5 / 16'hF14A.
- Reset low, then release; `mode`=11, `in`=12'h004, `load`=1 for one edge -> after that edge `out_q`=16'h0008 and `q_valid`=1. `load`=0 on following edges -> `out_q` holds 16'h0008.
- With `q_valid`=1, pull `rst_n` low between clock edges -> `out_q`=16'h0000 and `q_valid`=0 immediately, with no clock edge required.
- Random `in` (1000 vectors), `mode`=00 -> `out` == `ext` == 16-bit sign extension of `in` on every vector.
